// File: rtl/branch_decode.sv
// Thumb branch decoder: recognises B<cond>, B and two-halfword BL and emits a registered branch strobe.
// Optional taken-branch counter enabled by defining BRANCH_DECODE_COUNT_EN.
module branch_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  input  logic [31:0] pc,
  input  logic [3:0]  flags,
  output logic        branch_valid,
  output logic        link,
  output logic [31:0] offset,
  output logic [31:0] branch_pc,
  output logic        bl_err,
  output logic        bl_pending,
  output logic [15:0] branch_count
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] BL_WAIT = 1'b1;

  logic [0:0]  state, next_state;
  logic        hold_s;
  logic [9:0]  hold_imm10;
  logic [31:0] hold_pc;

  logic        take, take_link, latch_prefix, err;
  logic [31:0] take_off, take_pc;
  logic        i1, i2;

  // flags are {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = ~c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = c & ~z;
      4'h9:    cond_pass = ~c | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      default: cond_pass = 1'b0;
    endcase
  endfunction

  always_comb begin
    take         = 1'b0;
    take_link    = 1'b0;
    take_off     = 32'd0;
    take_pc      = pc;
    latch_prefix = 1'b0;
    err          = 1'b0;
    next_state   = state;
    i1           = 1'b0;
    i2           = 1'b0;
    if (instr_valid) begin
      if (state == IDLE) begin
        if (instr[15:12] == 4'hD && instr[11:8] <= 4'hD) begin
          take     = cond_pass(instr[11:8], flags);
          take_off = {{23{instr[7]}}, instr[7:0], 1'b0} + 32'd4;
        end else if (instr[15:11] == 5'b11100) begin
          take     = 1'b1;
          take_off = {{20{instr[10]}}, instr[10:0], 1'b0} + 32'd4;
        end else if (instr[15:11] == 5'b11110) begin
          latch_prefix = 1'b1;
          next_state   = BL_WAIT;
        end
      end else begin
        // the halfword after a prefix is consumed either way, never re-decoded
        next_state = IDLE;
        if (instr[15:14] == 2'b11 && instr[12]) begin
          i1        = ~(instr[13] ^ hold_s);
          i2        = ~(instr[11] ^ hold_s);
          take      = 1'b1;
          take_link = 1'b1;
          take_pc   = hold_pc;
          take_off  = {{7{hold_s}}, hold_s, i1, i2, hold_imm10, instr[10:0], 1'b0} + 32'd4;
        end else begin
          err = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bl_pending   <= 1'b0;
      branch_valid <= 1'b0;
      bl_err       <= 1'b0;
      link         <= 1'b0;
      offset       <= 32'd0;
      branch_pc    <= 32'd0;
      hold_s       <= 1'b0;
      hold_imm10   <= 10'd0;
      hold_pc      <= 32'd0;
    end else begin
      state        <= next_state;
      bl_pending   <= (next_state == BL_WAIT);
      branch_valid <= take;
      bl_err       <= err;
      if (take) begin
        link      <= take_link;
        offset    <= take_off;
        branch_pc <= take_pc;
      end
      if (latch_prefix) begin
        hold_s     <= instr[10];
        hold_imm10 <= instr[9:0];
        hold_pc    <= pc;
      end
    end
  end

`ifdef BRANCH_DECODE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       branch_count <= 16'd0;
    else if (take) branch_count <= branch_count + 16'd1;
  end
`else
  assign branch_count = 16'd0;
`endif

endmodule

// File: tb/tb_branch_decode.sv
// Self-checking bench for branch_decode: directed vector table plus BL, error, reset and counter sequences.
module tb_branch_decode;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'd0;
  logic [31:0] pc = 32'd0;
  logic [3:0]  flags = 4'd0;
  logic        branch_valid, link, bl_err, bl_pending;
  logic [31:0] offset, branch_pc;
  logic [15:0] branch_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [31:0] exp_off = 32'd0;

  branch_decode dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc(pc), .flags(flags),
    .branch_valid(branch_valid), .link(link), .offset(offset), .branch_pc(branch_pc),
    .bl_err(bl_err), .bl_pending(bl_pending), .branch_count(branch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [31:0] pc;
    logic [3:0]  flags;
    logic        exp_v;
    logic [31:0] exp_off;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] i, input logic [31:0] p, input logic [3:0] f);
    instr_valid = v; instr = i; pc = p; flags = f;
    @(negedge clk);
  endtask

  task automatic chk_strobe(input string name, input logic [31:0] bpc, input logic lnk);
    chk({name, ".valid"}, {31'd0, branch_valid}, 32'd1);
    chk({name, ".link"}, {31'd0, link}, {31'd0, lnk});
    chk({name, ".offset"}, offset, exp_off);
    chk({name, ".pc"}, branch_pc, bpc);
    exp_cnt++;
  endtask

  initial begin
    // flags = {N,Z,C,V}
    vecs[0]  = '{16'hE7FE, 32'h100, 4'b0000, 1'b1, 32'h00000000};
    vecs[1]  = '{16'hD0FE, 32'h104, 4'b0100, 1'b1, 32'h00000000};
    vecs[2]  = '{16'hD0FE, 32'h108, 4'b0000, 1'b0, 32'h0};
    vecs[3]  = '{16'hDC05, 32'h10C, 4'b1001, 1'b1, 32'h0000000E};
    vecs[4]  = '{16'hD101, 32'h110, 4'b0000, 1'b1, 32'h00000006};
    vecs[5]  = '{16'hD201, 32'h114, 4'b0000, 1'b0, 32'h0};
    vecs[6]  = '{16'hD801, 32'h118, 4'b0010, 1'b1, 32'h00000006};
    vecs[7]  = '{16'hD901, 32'h11C, 4'b0010, 1'b0, 32'h0};
    vecs[8]  = '{16'hDB01, 32'h120, 4'b1000, 1'b1, 32'h00000006};
    vecs[9]  = '{16'hDD01, 32'h124, 4'b0000, 1'b0, 32'h0};
    vecs[10] = '{16'hDE00, 32'h128, 4'b1111, 1'b0, 32'h0};
    vecs[11] = '{16'hDF00, 32'h12C, 4'b1111, 1'b0, 32'h0};
    vecs[12] = '{16'hD080, 32'h130, 4'b0100, 1'b1, 32'hFFFFFF04};
    vecs[13] = '{16'hE400, 32'h134, 4'b0000, 1'b1, 32'hFFFFF804};
    vecs[14] = '{16'hE3FF, 32'h138, 4'b0000, 1'b1, 32'h00000802};
    vecs[15] = '{16'h2001, 32'h13C, 4'b0100, 1'b0, 32'h0};

    // reset held: every output 0
    @(negedge clk);
    @(negedge clk);
    chk("rst.valid", {31'd0, branch_valid}, 32'd0);
    chk("rst.offset", offset, 32'd0);
    chk("rst.pc", branch_pc, 32'd0);
    chk("rst.misc", {28'd0, link, bl_err, bl_pending, 1'b0}, 32'd0);
    chk("rst.count", {16'd0, branch_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 16; k++) begin
      step(1'b1, vecs[k].instr, vecs[k].pc, vecs[k].flags);
      if (vecs[k].exp_v) begin
        exp_off = vecs[k].exp_off;
        chk_strobe($sformatf("vec%0d", k), vecs[k].pc, 1'b0);
      end else begin
        chk($sformatf("vec%0d.valid", k), {31'd0, branch_valid}, 32'd0);
        chk($sformatf("vec%0d.hold", k), offset, exp_off);
      end
      chk($sformatf("vec%0d.err", k), {31'd0, bl_err}, 32'd0);
    end
    step(1'b0, 16'h0, 32'h0, 4'h0);
    chk("idle.valid", {31'd0, branch_valid}, 32'd0);

    // BL 0xF000,0xF800
    step(1'b1, 16'hF000, 32'h200, 4'h0);
    chk("bl1.pending", {31'd0, bl_pending}, 32'd1);
    chk("bl1.nostrobe", {31'd0, branch_valid}, 32'd0);
    step(1'b1, 16'hF800, 32'h202, 4'h0);
    exp_off = 32'h00000004;
    chk_strobe("bl1", 32'h200, 1'b1);
    chk("bl1.done", {31'd0, bl_pending}, 32'd0);

    // BL 0xF7FF,0xFFFE: backward offset that cancels the bias
    step(1'b1, 16'hF7FF, 32'h210, 4'h0);
    step(1'b1, 16'hFFFE, 32'h212, 4'h0);
    exp_off = 32'h00000000;
    chk_strobe("bl2", 32'h210, 1'b1);

    // gap of two idle cycles inside a pair
    step(1'b1, 16'hF000, 32'h300, 4'h0);
    step(1'b0, 16'hF800, 32'h0, 4'h0);
    step(1'b0, 16'h0000, 32'h0, 4'h0);
    chk("gap.pending", {31'd0, bl_pending}, 32'd1);
    chk("gap.nostrobe", {31'd0, branch_valid}, 32'd0);
    step(1'b1, 16'hF800, 32'h306, 4'h0);
    exp_off = 32'h00000004;
    chk_strobe("gap", 32'h300, 1'b1);

    // bad suffix: one-cycle bl_err, halfword discarded
    step(1'b1, 16'hF000, 32'h400, 4'h0);
    step(1'b1, 16'h2001, 32'h402, 4'h0);
    chk("err.pulse", {31'd0, bl_err}, 32'd1);
    chk("err.nostrobe", {31'd0, branch_valid}, 32'd0);
    chk("err.idle", {31'd0, bl_pending}, 32'd0);
    step(1'b0, 16'h0, 32'h0, 4'h0);
    chk("err.width", {31'd0, bl_err}, 32'd0);
    chk("err.hold", offset, exp_off);

    // reset during a held prefix
    step(1'b1, 16'hF000, 32'h500, 4'h0);
    instr_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst.pending", {31'd0, bl_pending}, 32'd0);
    chk("midrst.offset", offset, 32'd0);
    exp_off = 32'd0;
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 16'h0, 32'h0, 4'h0);
    chk("midrst.valid", {31'd0, branch_valid}, 32'd0);
    chk("midrst.err", {31'd0, bl_err}, 32'd0);

    // back-to-back strobes
    exp_off = 32'h00000000;
    step(1'b1, 16'hE7FE, 32'h600, 4'h0);
    chk_strobe("b2b0", 32'h600, 1'b0);
    step(1'b1, 16'hE7FE, 32'h602, 4'h0);
    chk_strobe("b2b1", 32'h602, 1'b0);
    step(1'b1, 16'hE7FE, 32'h604, 4'h0);
    chk_strobe("b2b2", 32'h604, 1'b0);
    step(1'b0, 16'h0, 32'h0, 4'h0);
    chk("b2b.end", {31'd0, branch_valid}, 32'd0);

`ifdef BRANCH_DECODE_COUNT_EN
    chk("count3", {16'd0, branch_count}, 32'd3);
    for (int k = exp_cnt; k < 65536; k++) step(1'b1, 16'hE7FE, 32'h700, 4'h0);
    step(1'b0, 16'h0, 32'h0, 4'h0);
    chk("count.wrap", {16'd0, branch_count}, 32'd0);
`else
    chk("count.off", {16'd0, branch_count}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_decode.md
# branch_decode

Decodes 16-bit Thumb halfwords from the fetch stream and recognises the ARMv6-M branch forms B<cond>, B and the two-halfword BL. It sits directly upstream of the branch execution stage and feeds it a registered branch strobe, a link flag and a signed 32-bit offset. The offset is relative to the address of the (first) branch halfword and already includes the Thumb PC+4 bias, so the downstream target is simply pc + offset. Non-branch halfwords pass by without producing output.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  instr/pc are valid this cycle and are consumed
- instr  in  16  fetched halfword
- pc  in  32  address of instr
- flags  in  4  {N,Z,C,V}, sampled in the cycle the branch completes
- branch_valid  out  1  one-cycle strobe: taken branch decoded
- link  out  1  the strobed branch is BL
- offset  out  32  signed byte offset from the first-halfword address, bias included
- branch_pc  out  32  address of the first halfword of the strobed branch
- bl_err  out  1  one-cycle strobe: BL prefix not followed by a valid suffix
- bl_pending  out  1  first BL halfword held, waiting for the suffix
- branch_count  out  16  taken-branch counter (see Configuration)

## Operation
- FSM states: IDLE, BL_WAIT.
- IDLE, instr_valid=1:
  - instr[15:12]=1101 with cond=instr[11:8] ≤ 1101: evaluate cond. If true, offset = sext(instr[7:0]:0)+4 and link=0. If false, no output.
  - cond 1110 (UDF) or 1111 (SVC): not a branch, no output.
  - instr[15:11]=11100: offset = sext(instr[10:0]:0)+4, link=0, always taken.
  - instr[15:11]=11110: latch S=instr[10], imm10=instr[9:0] and pc into a holding register, then go to BL_WAIT. No strobe.
- BL_WAIT, instr_valid=1:
  - Suffix valid when instr[15:14]=11 and instr[12]=1. Then:
    - J1=instr[13], J2=instr[11]
    - I1=~(J1^S), I2=~(J2^S)
    - offset = sext(S:I1:I2:imm10:instr[10:0]:0)+4
    - link=1, branch_pc = held pc
    - go to IDLE
  - Any other halfword: pulse bl_err, discard the halfword (it is not re-decoded) and go to IDLE.
- BL_WAIT with instr_valid=0: hold state indefinitely.
- Condition codes, in order 0000..1101: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- Offset arithmetic is 32-bit two's complement. The +4 wraps modulo 2^32.
- link, offset and branch_pc update only when branch_valid is strobed, and hold their values otherwise.

## Timing
- Reset values: FSM=IDLE, every output 0, holding register 0.
- Latency: branch_valid rises in the cycle after the accepting clock edge of the completing halfword (B/B<cond>: the halfword itself; BL: the suffix).
- branch_valid and bl_err are exactly one cycle wide. Back-to-back branches produce back-to-back strobes.
- bl_pending = (state==BL_WAIT), driven registered.
- Reset asserted mid-BL abandons the held prefix: state returns to IDLE immediately, and no strobe or error is produced.
- There is no backpressure. Every valid halfword is consumed in its cycle.

## Configuration
- BRANCH_DECODE_COUNT_EN defined: branch_count increments by 1 on every branch_valid strobe and wraps 0xFFFF→0x0000. It is cleared by rst.
- BRANCH_DECODE_COUNT_EN undefined: the counter logic is removed and branch_count is tied to 0. All other behaviour is identical.

## Test plan
- Reset with rst=1 mid-stream → all outputs 0 and the FSM is in IDLE. Deassert, then feed 0xE7FE at pc=0x100 → next cycle branch_valid=1, offset=0x00000000, link=0, branch_pc=0x100.
- 0xD0FE with flags Z=1 → strobe, offset=0. Same halfword with Z=0 → no strobe. 0xDC05 (GT) with N=1,V=1,Z=0 → offset=0x0000000E.
- 0xF000 at pc=0x200, then 0xF800 → bl_pending=1 between the halfwords, then strobe with link=1, offset=0x00000004, branch_pc=0x200. Pair 0xF7FF,0xFFFE → offset=0x00000000.
- 0xF000 followed by 0x2001 → bl_err pulses for one cycle, no branch_valid, FSM returns to IDLE. 0xF000, then rst asserted → no outputs, bl_pending=0.
- 0xDE00 and 0xDF00 → no strobe. A 2-cycle instr_valid gap inside a BL pair → the BL still completes correctly.
- With BRANCH_DECODE_COUNT_EN: 3 taken branches → branch_count=3. Preload via 65536 strobes → count wraps to 0. Without the macro → branch_count stays 0.
